// File: rtl/mem_arbiter_if.sv
// Signal bundle between the I/D requesters, the arbiter and the shared slow memory.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rdy;
  logic [31:0] i_data;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rdy;
  logic [31:0] d_data;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  logic        err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_rdy, i_data, d_rdy, d_data, mem_en, mem_addr, mem_we, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_rdy, i_data, d_rdy, d_data, mem_en, mem_addr, mem_we, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between an I-refill port and a D port,
// with a sticky watchdog error for a memory that never answers.
module mem_arbiter #(
  parameter int MAX_WAIT = 16,
  parameter int CW       = 5
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t      state;
  port_t       last;
  logic [CW-1:0] wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] i_data_q;
  logic [31:0] d_data_q;
  logic        i_rdy_q;
  logic        d_rdy_q;
  logic        err_q;

  logic busy;
  logic grant_i;
  logic grant_d;
  logic timeout;

  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  // When both ask, the port that was served last yields.
  assign grant_i = bus.i_req && (!bus.d_req || last == PORT_D);
  assign grant_d = bus.d_req && !grant_i;
  assign timeout = (wait_cnt == LAST_WAIT);

  // NOTE: every register below uses non-blocking assignment so all state updates
  // see pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= PORT_D;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_i) begin
            addr_q <= bus.i_addr;
            we_q   <= 1'b0;
            last   <= PORT_I;
            state  <= BUSY_I;
          end else if (grant_d) begin
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
            last    <= PORT_D;
            state   <= BUSY_D;
          end
        end

        BUSY_I, BUSY_D: begin
          if (!timeout) wait_cnt <= wait_cnt + CW'(1);
          // A ready on the final allowed cycle still counts as a normal completion.
          if (bus.mem_rdy) begin
            if (state == BUSY_I) begin
              i_data_q <= bus.mem_rdata;
              i_rdy_q  <= 1'b1;
            end else begin
              if (!we_q) d_data_q <= bus.mem_rdata;
              d_rdy_q <= 1'b1;
            end
            state <= RELEASE;
          end else if (timeout) begin
            if (state == BUSY_I) begin
              i_data_q <= '0;
              i_rdy_q  <= 1'b1;
            end else begin
              if (!we_q) d_data_q <= '0;
              d_rdy_q <= 1'b1;
            end
            err_q <= 1'b1;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          i_rdy_q <= 1'b0;
          d_rdy_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = busy;
  assign bus.mem_we    = we_q && (state == BUSY_D);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdy     = i_rdy_q;
  assign bus.i_data    = i_data_q;
  assign bus.d_rdy     = d_rdy_q;
  assign bus.d_data    = d_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a
// randomized phase compared against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CW(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slow memory: ready once mem_en has been high for nd posedges.
  logic [31:0] mem [64];
  int  nd = 3;
  int  en_cnt = 0;
  bit  mem_never;
  bit  stray_rdy;
  bit  mem_init;

  function automatic logic [31:0] init_word(int i);
    if (i == 8) return 32'h2008_0005;
    if (i == 4) return 32'h4444_0004;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always_ff @(posedge clk) begin
    en_cnt <= bus.mem_en ? en_cnt + 1 : 0;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (bus.mem_en && bus.mem_rdy && bus.mem_we) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdy   = stray_rdy || (bus.mem_en && !mem_never && en_cnt >= nd);
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    stray_rdy   = 1'b0;
    mem_never   = 1'b0;
    mem_init    = 1'b1;
    tick();
    mem_init = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Waits for a completion pulse. lat counts posedges since the granting edge;
  // port is 0 for I, 1 for D, -1 if nothing completed within the budget.
  task automatic wait_done(output int port, output int lat, output int en_cyc, output int we_cyc);
    bit started;
    int both;
    int we_bad;
    port = -1; lat = 0; en_cyc = 0; we_cyc = 0;
    started = 1'b0; both = 0; we_bad = 0;
    for (int b = 0; b < 60; b++) begin
      tick();
      if (started) lat++;
      if (bus.mem_en) begin
        started = 1'b1;
        en_cyc++;
        if (bus.mem_we) we_cyc++;
      end else if (bus.mem_we) begin
        we_bad++;
      end
      if (bus.i_rdy && bus.d_rdy) both++;
      if (bus.i_rdy || bus.d_rdy) begin
        port = bus.d_rdy ? 1 : 0;
        break;
      end
    end
    check("rdy_exclusive", 32'(both), 32'h0);
    check("mem_we_outside_busy", 32'(we_bad), 32'h0);
  endtask

  task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int port, output int lat,
                        output int en_cyc, output int we_cyc);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    wait_done(port, lat, en_cyc, we_cyc);
    tick();
    check("rdy_single_pulse", 32'({bus.i_rdy, bus.d_rdy}), 32'h0);
    if (is_d) begin
      bus.d_req = 1'b0; bus.d_we = 1'b0;
    end else begin
      bus.i_req = 1'b0;
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          nd;
    bit          never;
    int          exp_lat;
    logic [31:0] exp_data;
    bit          exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int port, lat, en_cyc, we_cyc, seen;
    int last_ref, exp_port;
    bit ref_err;
    logic [31:0] ref_i, ref_d;
    logic [31:0] ref_mem [64];

    // Reset state
    do_reset();
    check("rst_i_rdy",     32'(bus.i_rdy),  32'h0);
    check("rst_d_rdy",     32'(bus.d_rdy),  32'h0);
    check("rst_i_data",    bus.i_data,      32'h0);
    check("rst_d_data",    bus.d_data,      32'h0);
    check("rst_mem_en",    32'(bus.mem_en), 32'h0);
    check("rst_mem_we",    32'(bus.mem_we), 32'h0);
    check("rst_mem_addr",  bus.mem_addr,    32'h0);
    check("rst_mem_wdata", bus.mem_wdata,   32'h0);
    check("rst_err",       32'(bus.err),    32'h0);

    // A ready from the memory while idle must be ignored
    stray_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stray_rdy_idle", 32'({bus.i_rdy, bus.d_rdy, bus.err, bus.mem_en}), 32'h0);
    end
    stray_rdy = 1'b0;

    // Vector table: each entry starts from reset
    vecs[0] = '{1'b0, 1'b0, 6'h08, 32'h0,         3,  1'b0, 4,        32'h2008_0005, 1'b0, 32'h2008_0005};
    vecs[1] = '{1'b1, 1'b0, 6'h08, 32'h0,         1,  1'b0, 2,        32'h2008_0005, 1'b0, 32'h2008_0005};
    vecs[2] = '{1'b1, 1'b0, 6'h04, 32'h0,         15, 1'b0, 16,       32'h4444_0004, 1'b0, 32'h4444_0004};
    vecs[3] = '{1'b0, 1'b0, 6'h04, 32'h0,         16, 1'b0, MAX_WAIT, 32'h0,         1'b1, 32'h4444_0004};
    vecs[4] = '{1'b1, 1'b1, 6'h10, 32'hCAFE_F00D, 2,  1'b0, 3,        32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b1, 6'h11, 32'h1234_5678, 3,  1'b1, MAX_WAIT, 32'h0,         1'b1, 32'hC0DE_0011};
    vecs[6] = '{1'b0, 1'b0, 6'h3F, 32'h0,         0,  1'b0, 1,        32'hC0DE_003F, 1'b0, 32'hC0DE_003F};

    for (int i = 0; i < 7; i++) begin
      do_reset();
      nd = vecs[i].nd;
      mem_never = vecs[i].never;
      do_txn(vecs[i].is_d, vecs[i].we, 32'(vecs[i].addr), vecs[i].wdata, port, lat, en_cyc, we_cyc);
      check($sformatf("vec%0d_port", i), 32'(port), 32'(vecs[i].is_d));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_mem_en_cycles", i), 32'(en_cyc), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_mem_we_cycles", i), 32'(we_cyc), vecs[i].we ? 32'(vecs[i].exp_lat) : 32'h0);
      check($sformatf("vec%0d_data", i), vecs[i].is_d ? bus.d_data : bus.i_data, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_mem_addr", i), bus.mem_addr, 32'(vecs[i].addr));
      check($sformatf("vec%0d_mem_word", i), mem[vecs[i].addr], vecs[i].exp_word);
    end

    // Both ports requesting continuously: strict alternation starting with I
    do_reset();
    nd = 2;
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      wait_done(port, lat, en_cyc, we_cyc);
      check("rr_order", 32'(port), 32'(k % 2));
      check("rr_data", port == 1 ? bus.d_data : bus.i_data,
            (k % 2) == 1 ? 32'h4444_0004 : 32'h2008_0005);
      tick();
      if (k % 2 == 1) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      tick();
      if (k < 3) begin
        if (k % 2 == 1) bus.d_req = 1'b1; else bus.i_req = 1'b1;
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    check("rr_err", 32'(bus.err), 32'h0);

    // D write then I read of the same word
    do_reset();
    nd = 3;
    do_txn(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, port, lat, en_cyc, we_cyc);
    check("wr_we_cycles", 32'(we_cyc), 32'h4);
    check("wr_d_data_kept", bus.d_data, 32'h0);
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, port, lat, en_cyc, we_cyc);
    check("rd_after_wr_we_cycles", 32'(we_cyc), 32'h0);
    check("rd_after_wr_i_data", bus.i_data, 32'hDEAD_BEEF);

    // Timeout on a D read after a good one, then recovery with err sticky
    do_reset();
    nd = 2;
    do_txn(1'b1, 1'b0, 32'h8, 32'h0, port, lat, en_cyc, we_cyc);
    check("pre_to_d_data", bus.d_data, 32'h2008_0005);
    mem_never = 1'b1;
    do_txn(1'b1, 1'b0, 32'h4, 32'h0, port, lat, en_cyc, we_cyc);
    check("to_latency", 32'(lat), 32'(MAX_WAIT));
    check("to_d_data", bus.d_data, 32'h0);
    check("to_err", 32'(bus.err), 32'h1);
    repeat (10) tick();
    check("to_err_sticky", 32'(bus.err), 32'h1);
    mem_never = 1'b0;
    nd = 3;
    do_txn(1'b0, 1'b0, 32'h8, 32'h0, port, lat, en_cyc, we_cyc);
    check("post_to_latency", 32'(lat), 32'h4);
    check("post_to_i_data", bus.i_data, 32'h2008_0005);
    check("post_to_err", 32'(bus.err), 32'h1);

    // Reset in the second BUSY cycle aborts the access
    do_reset();
    nd = 3;
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    tick();
    check("abort_busy", 32'(bus.mem_en), 32'h1);
    tick();
    #3 reset = 1'b1;
    #1;
    check("abort_mem_en_async", 32'(bus.mem_en), 32'h0);
    check("abort_mem_we_async", 32'(bus.mem_we), 32'h0);
    bus.i_req = 1'b0;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.i_rdy || bus.d_rdy || bus.mem_en) seen++;
    end
    check("abort_no_rdy", 32'(seen), 32'h0);
    do_txn(1'b0, 1'b0, 32'h8, 32'h0, port, lat, en_cyc, we_cyc);
    check("abort_recover_latency", 32'(lat), 32'h4);
    check("abort_recover_data", bus.i_data, 32'h2008_0005);

    // Request withdrawn right after grant still completes once
    do_reset();
    nd = 3;
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    tick();
    check("drop_granted", 32'(bus.mem_en), 32'h1);
    bus.i_req = 1'b0;
    wait_done(port, lat, en_cyc, we_cyc);
    check("drop_port", 32'(port), 32'h0);
    check("drop_i_data", bus.i_data, 32'h2008_0005);
    tick();
    check("drop_single_pulse", 32'(bus.i_rdy), 32'h0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.mem_en || bus.i_rdy) seen++;
    end
    check("drop_no_regrant", 32'(seen), 32'h0);

    // Randomized rounds against a transaction-level model
    do_reset();
    last_ref = 1;
    ref_err = 1'b0;
    ref_i = '0;
    ref_d = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    for (int r = 0; r < 40; r++) begin
      bit wi, wd, dwe, to;
      logic [5:0] ia, da;
      logic [31:0] dw;
      wi  = ($urandom_range(0, 1) == 1);
      wd  = ($urandom_range(0, 1) == 1);
      if (!wi && !wd) wi = 1'b1;
      dwe = ($urandom_range(0, 1) == 1);
      ia  = 6'($urandom_range(0, 63));
      da  = 6'($urandom_range(0, 63));
      dw  = $urandom;
      nd  = int'($urandom_range(0, 5));
      mem_never = ($urandom_range(0, 7) == 0);
      to = mem_never;
      if (wi) begin bus.i_req = 1'b1; bus.i_addr = 32'(ia); end
      if (wd) begin bus.d_req = 1'b1; bus.d_we = dwe; bus.d_addr = 32'(da); bus.d_wdata = dw; end
      exp_port = (wi && wd) ? (last_ref == 1 ? 0 : 1) : (wd ? 1 : 0);
      for (int t = 0; t < int'(wi) + int'(wd); t++) begin
        wait_done(port, lat, en_cyc, we_cyc);
        check("rnd_port", 32'(port), 32'(exp_port));
        check("rnd_latency", 32'(lat), to ? 32'(MAX_WAIT) : 32'(nd + 1));
        if (exp_port == 0) ref_i = to ? 32'h0 : ref_mem[ia];
        else if (!dwe)     ref_d = to ? 32'h0 : ref_mem[da];
        else if (!to)      ref_mem[da] = dw;
        if (to) ref_err = 1'b1;
        check("rnd_i_data", bus.i_data, ref_i);
        check("rnd_d_data", bus.d_data, ref_d);
        check("rnd_err", 32'(bus.err), 32'(ref_err));
        last_ref = exp_port;
        tick();
        check("rnd_single_pulse", 32'({bus.i_rdy, bus.d_rdy}), 32'h0);
        if (exp_port == 0) bus.i_req = 1'b0;
        else begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
        exp_port = 1 - exp_port;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow, fixed-latency memory between the instruction-cache refill port (I) and the data-memory port (D).
- Sequences each memory access: grant, hold address until the memory is ready, return data, release.
- Arbitrates with round-robin fairness, and has a watchdog timeout for a memory that never responds.
- Sits between im_cached-style caches and the single slow memory model.

Parameters:
- MAX_WAIT, 16: memory-ready timeout in cycles, counted from grant; must be >= 2.
- CW, 5: width of the wait counter; must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  I-port request; held until i_rdy.
- i_addr  in  32  I-port word address.
- i_rdy  out  1  one-cycle completion pulse.
- i_data  out  32  I-port read data; valid while i_rdy=1, held afterwards.
- d_req  in  1  D-port request; held until d_rdy.
- d_we  in  1  D-port write enable; 1 = write.
- d_addr  in  32  D-port address.
- d_wdata  in  32  D-port write data.
- d_rdy  out  1  one-cycle completion pulse.
- d_data  out  32  D-port read data; updated on reads only.
- mem_en  out  1  memory access active; the memory counts its latency while this is high.
- mem_addr  out  32  address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  memory read data; valid when mem_rdy=1.
- mem_rdy  in  1  memory ready.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last=D, wait counter=0.
  - All outputs 0, including i_data, d_data and err.
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE:
  - mem_en=0, mem_we=0.
  - Requests are sampled only here.
  - At a posedge: if exactly one req is high, grant it.
  - If both are high, grant the port not equal to last.
  - Granting: latch the port's addr, and for D also we and wdata, into mem_addr/mem_we/mem_wdata. Next state is BUSY_x. Set last=x. Clear the counter.
- BUSY_x:
  - mem_en=1; mem_addr/mem_we/mem_wdata are stable registered values.
  - Requester inputs are ignored after the grant.
  - Counter increments each cycle.
  - At a posedge with mem_rdy=1:
    - For a read, x_data<=mem_rdata.
    - For a D write, d_data is unchanged.
    - x_rdy<=1; next state is RELEASE.
  - Otherwise, if counter==MAX_WAIT-1: timeout.
    - x_data<=0 (for a D write, d_data is unchanged).
    - x_rdy<=1, err<=1; next state is RELEASE.
- RELEASE (exactly one cycle):
  - mem_en=0, mem_we=0, so the memory's latency counter restarts.
  - x_rdy=1 during this cycle only.
  - Next state is IDLE; requests are not sampled in this cycle.
- Requester rule: drop or change req at the posedge that ends the x_rdy cycle. Back-to-back requests from the same port are therefore separated by one IDLE cycle.
- Latency: with a memory that raises mem_rdy after mem_en has been high for ND posedges, i_rdy/d_rdy assert ND+1 cycles after the granting posedge.
- If req drops while granted, the transaction still completes and x_rdy still pulses.
- mem_rdy seen in IDLE or RELEASE is ignored.
- If mem_rdy and the timeout coincide, mem_rdy wins: data is captured and err is not set.
- err clears only on reset.
- The counter saturates and never wraps.
- i_rdy and d_rdy are never high together.
- Reset mid-BUSY aborts the access: mem_en drops asynchronously and no rdy pulses.

Test Plan:
1. Memory ND=3, word 0x20080005 at address 0x8. Assert i_req with i_addr=0x8 -> i_rdy is a single pulse 4 cycles after grant; i_data=0x20080005; d_rdy stays 0; mem_en is high for exactly 4 cycles.
2. i_req and d_req both held from reset, each re-asserted after its rdy -> grant order is I, D, I, D; no overlap on mem_en; err=0.
3. D write of 0xDEADBEEF to 0x10 (d_we=1), then I read of 0x10 -> mem_we=1 only during BUSY_D; d_data remains 0; i_data=0xDEADBEEF.
4. Memory model never asserts mem_rdy, MAX_WAIT=16, D read of 0x4 -> d_rdy pulses 16 cycles after grant; d_data=0; err=1 and still 1 after 10 more idle cycles; a following I read completes normally with err still 1.
5. reset pulsed during cycle 2 of BUSY_I -> mem_en=0 immediately; i_rdy never pulses; after reset, an I read of 0x8 returns 0x20080005 with normal latency.
6. i_req dropped the cycle after grant -> i_rdy still pulses once with data; the arbiter returns to IDLE and does not re-grant I.
